// File: rtl/ddr_wb_local_bridge.sv
// Single-beat Wishbone slave that issues requests on a DDR controller local interface.
// Define DDR_WB_TIMEOUT_EN to compile in the request timeout / wb_err_o path.
module ddr_wb_local_bridge #(
    parameter int DATA_W  = 32,
    parameter int ROW_W   = 13,
    parameter int BANK_W  = 2,
    parameter int COL_W   = 8,
    parameter bit AUTOPCH = 1'b0,
    parameter int TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [31:0]           wb_adr_i,
    input  logic [DATA_W-1:0]     wb_dat_i,
    input  logic [DATA_W/8-1:0]   wb_sel_i,
    input  logic                  wb_we_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    output logic [DATA_W-1:0]     wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  local_read_req,
    output logic                  local_write_req,
    output logic                  local_burstbegin,
    output logic [1:0]            local_size,
    output logic                  local_autopch_req,
    output logic                  local_cs_addr,
    output logic [ROW_W-1:0]      local_row_addr,
    output logic [BANK_W-1:0]     local_bank_addr,
    output logic [COL_W-1:0]      local_col_addr,
    output logic [DATA_W-1:0]     local_wdata,
    output logic [DATA_W/8-1:0]   local_be,
    input  logic                  local_ready,
    input  logic                  local_rdata_valid,
    input  logic [DATA_W-1:0]     local_rdata,
    input  logic                  local_init_done
);
    localparam int SEL_W    = DATA_W / 8;
    localparam int COL_LSB  = 2;
    localparam int BANK_LSB = COL_LSB + COL_W;
    localparam int ROW_LSB  = BANK_LSB + BANK_W;
    localparam int ADR_TOP  = ROW_LSB + ROW_W;

    typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_RWAIT, ST_ACK, ST_ERR} state_t;

    state_t              r_state;
    logic                r_we;
    logic                r_rd_req;
    logic                r_wr_req;
    logic                r_burstbegin;
    logic                r_ack;
    logic [ROW_W-1:0]    r_row;
    logic [BANK_W-1:0]   r_bank;
    logic [COL_W-1:0]    r_col;
    logic [DATA_W-1:0]   r_wdata;
    logic [SEL_W-1:0]    r_be;
    logic [DATA_W-1:0]   r_rdata;
    logic                w_start;
    logic                w_null_wr;
    logic                w_unused;

`ifdef DDR_WB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    logic [TMO_W-1:0]    r_tmo_cnt;
    logic                r_err;
    logic                w_tmo;
    assign w_tmo    = (r_tmo_cnt == TMO_LAST);
    assign wb_err_o = r_err;
    assign w_unused = ^{wb_adr_i[31:ADR_TOP], wb_adr_i[1:0]};
`else
    assign wb_err_o = 1'b0;
    assign w_unused = ^{wb_adr_i[31:ADR_TOP], wb_adr_i[1:0], TIMEOUT[0]};
`endif

    assign w_start   = wb_cyc_i & wb_stb_i & local_init_done;
    assign w_null_wr = wb_we_i & (wb_sel_i == '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_we         <= 1'b0;
            r_rd_req     <= 1'b0;
            r_wr_req     <= 1'b0;
            r_burstbegin <= 1'b0;
            r_ack        <= 1'b0;
            r_row        <= '0;
            r_bank       <= '0;
            r_col        <= '0;
            r_wdata      <= '0;
            r_be         <= '0;
            r_rdata      <= '0;
`ifdef DDR_WB_TIMEOUT_EN
            r_tmo_cnt    <= '0;
            r_err        <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_row   <= wb_adr_i[ROW_LSB +: ROW_W];
                        r_bank  <= wb_adr_i[BANK_LSB +: BANK_W];
                        r_col   <= wb_adr_i[COL_LSB +: COL_W];
                        r_wdata <= wb_dat_i;
                        r_be    <= wb_sel_i;
                        r_we    <= wb_we_i;
                        if (w_null_wr) begin
                            r_state <= ST_ACK;
                        end else begin
                            r_state      <= ST_CMD;
                            r_wr_req     <= wb_we_i;
                            r_rd_req     <= ~wb_we_i;
                            r_burstbegin <= 1'b1;
`ifdef DDR_WB_TIMEOUT_EN
                            r_tmo_cnt    <= '0;
`endif
                        end
                    end
                end
                ST_CMD: begin
                    r_burstbegin <= 1'b0;
                    if (local_ready) begin
                        r_wr_req <= 1'b0;
                        r_rd_req <= 1'b0;
                        if (r_we) begin
                            r_ack   <= 1'b1;
                            r_state <= ST_ACK;
                        end else begin
                            r_state <= ST_RWAIT;
                        end
                    end
`ifdef DDR_WB_TIMEOUT_EN
                    else if (w_tmo) begin
                        r_wr_req <= 1'b0;
                        r_rd_req <= 1'b0;
                        r_err    <= 1'b1;
                        r_state  <= ST_ERR;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
`endif
                end
                ST_RWAIT: begin
                    if (local_rdata_valid) begin
                        r_rdata <= local_rdata;
                        r_ack   <= 1'b1;
                        r_state <= ST_ACK;
                    end
`ifdef DDR_WB_TIMEOUT_EN
                    else if (w_tmo) begin
                        r_err   <= 1'b1;
                        r_state <= ST_ERR;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
`endif
                end
                ST_ACK: begin
                    // A null write arrives here with ack low and spends one silent
                    // cycle, so its ack lands at the same latency as a real write.
                    if (r_ack) begin
                        r_ack   <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_ack <= 1'b1;
                    end
                end
                ST_ERR: begin
`ifdef DDR_WB_TIMEOUT_EN
                    r_err <= 1'b0;
`endif
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign wb_dat_o          = r_rdata;
    assign wb_ack_o          = r_ack;
    assign local_read_req    = r_rd_req;
    assign local_write_req   = r_wr_req;
    assign local_burstbegin  = r_burstbegin;
    assign local_size        = 2'd1;
    assign local_autopch_req = AUTOPCH;
    assign local_cs_addr     = 1'b0;
    assign local_row_addr    = r_row;
    assign local_bank_addr   = r_bank;
    assign local_col_addr    = r_col;
    assign local_wdata       = r_wdata;
    assign local_be          = r_be;
endmodule

// File: tb/tb_ddr_wb_local_bridge.sv
// Scoreboard bench for ddr_wb_local_bridge: stimulus queues expected commands and
// responses, a negedge monitor pops and compares them against the DUT outputs.
module tb_ddr_wb_local_bridge;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o, wb_err_o;
    logic        local_read_req, local_write_req, local_burstbegin;
    logic [1:0]  local_size;
    logic        local_autopch_req, local_cs_addr;
    logic [12:0] local_row_addr;
    logic [1:0]  local_bank_addr;
    logic [7:0]  local_col_addr;
    logic [31:0] local_wdata, local_rdata;
    logic [3:0]  local_be;
    logic        local_ready, local_rdata_valid, local_init_done;

    always #5 clk = ~clk;

    ddr_wb_local_bridge #(.TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .wb_err_o(wb_err_o), .local_read_req(local_read_req), .local_write_req(local_write_req),
        .local_burstbegin(local_burstbegin), .local_size(local_size),
        .local_autopch_req(local_autopch_req), .local_cs_addr(local_cs_addr),
        .local_row_addr(local_row_addr), .local_bank_addr(local_bank_addr),
        .local_col_addr(local_col_addr), .local_wdata(local_wdata), .local_be(local_be),
        .local_ready(local_ready), .local_rdata_valid(local_rdata_valid),
        .local_rdata(local_rdata), .local_init_done(local_init_done)
    );

    typedef struct {
        bit          we;
        logic [12:0] row;
        logic [1:0]  bank;
        logic [7:0]  col;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          start;
        int          len;
    } cmd_t;
    typedef struct { bit is_err; bit chk_data; logic [31:0] data; int at; } rsp_t;
    typedef struct { int at; bit kind; logic [31:0] data; } snap_t;

    cmd_t  cmd_q[$];
    rsp_t  rsp_q[$];
    snap_t snap_q[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Controller model configuration, written only by the stimulus process.
    int          ctl_ready_low = 0;
    int          ctl_rv_delay  = 1;
    logic [31:0] ctl_rdata     = 32'd0;
    int          stray_req     = 0;
    bit          done          = 1'b0;

    initial begin : controller
        int low_cnt;
        int rv_cnt;
        int stray_seen;
        low_cnt = 0; rv_cnt = 0; stray_seen = 0;
        local_ready = 1'b0; local_rdata_valid = 1'b0; local_rdata = 32'd0;
        forever begin
            @(negedge clk);
            local_rdata_valid = 1'b0;
            if (rv_cnt > 0) begin
                rv_cnt = rv_cnt - 1;
                if (rv_cnt == 0) begin
                    local_rdata_valid = 1'b1;
                    local_rdata = ctl_rdata;
                end
            end
            if (stray_req != stray_seen) begin
                stray_seen = stray_req;
                local_rdata_valid = 1'b1;
                local_rdata = 32'h1234_5678;
            end
            if (local_read_req || local_write_req) begin
                if (low_cnt < ctl_ready_low) begin
                    local_ready = 1'b0;
                    low_cnt = low_cnt + 1;
                end else begin
                    local_ready = 1'b1;
                    low_cnt = 0;
                    if (local_read_req) rv_cnt = ctl_rv_delay;
                end
            end else begin
                local_ready = 1'b0;
                low_cnt = 0;
            end
        end
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        cmd_t  e;
        rsp_t  r;
        snap_t s;
        cmd_t  cur;
        bit    in_req;
        bit    bb_ok;
        bit    stable;
        logic  req;
        req = local_read_req | local_write_req;

        while (snap_q.size() > 0 && snap_q[0].at == cyc) begin
            s = snap_q.pop_front();
            if (s.kind == 1'b0) begin
                chk("rst_ctrl", 64'({local_read_req, local_write_req, local_burstbegin, wb_ack_o, wb_err_o}), 64'd0);
                chk("rst_dat_o", 64'(wb_dat_o), 64'd0);
                chk("rst_addr", 64'({local_row_addr, local_bank_addr, local_col_addr}), 64'd0);
                chk("rst_wdata_be", 64'({local_wdata, local_be}), 64'd0);
                chk("const_size_cs_apch", 64'({local_size, local_cs_addr, local_autopch_req}), 64'h4);
            end else begin
                chk("dat_o_hold", 64'(wb_dat_o), 64'(s.data));
            end
        end

        if (wb_ack_o || wb_err_o) begin
            if (rsp_q.size() == 0) begin
                chk("unexpected_rsp", 64'({wb_ack_o, wb_err_o}), 64'd0);
            end else begin
                r = rsp_q.pop_front();
                chk("rsp_kind", 64'({wb_ack_o, wb_err_o}), r.is_err ? 64'd1 : 64'd2);
                chk("rsp_cycle", 64'(cyc), 64'(r.at));
                if (r.chk_data) chk("rd_data", 64'(wb_dat_o), 64'(r.data));
            end
        end

        if (local_burstbegin && !req) chk("bb_without_req", 64'd1, 64'd0);
        if (req) begin
            if (!in_req) begin
                in_req = 1'b1;
                bb_ok  = local_burstbegin;
                stable = 1'b1;
                cur = '{local_write_req, local_row_addr, local_bank_addr, local_col_addr,
                        local_wdata, local_be, cyc, 0};
            end else if (local_burstbegin) begin
                bb_ok = 1'b0;
            end
            if ({local_read_req, local_write_req, local_row_addr, local_bank_addr, local_col_addr,
                 local_wdata, local_be} !== {~cur.we, cur.we, cur.row, cur.bank, cur.col, cur.wdata, cur.be})
                stable = 1'b0;
            cur.len = cur.len + 1;
        end else if (in_req) begin
            in_req = 1'b0;
            if (cmd_q.size() == 0) begin
                chk("unexpected_cmd", 64'd1, 64'd0);
            end else begin
                e = cmd_q.pop_front();
                chk("cmd_we", 64'(cur.we), 64'(e.we));
                chk("cmd_addr", 64'({cur.row, cur.bank, cur.col}), 64'({e.row, e.bank, e.col}));
                chk("cmd_wdata_be", 64'({cur.wdata, cur.be}), 64'({e.wdata, e.be}));
                chk("cmd_start", 64'(cur.start), 64'(e.start));
                chk("cmd_len", 64'(cur.len), 64'(e.len));
                chk("cmd_bb_first_only", 64'(bb_ok), 64'd1);
                chk("cmd_stable", 64'(stable), 64'd1);
            end
        end

        if (done) begin
            chk("cmd_q_drained", 64'(cmd_q.size()), 64'd0);
            chk("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
            chk("snap_q_drained", 64'(snap_q.size()), 64'd0);
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
        end
    end

    // One Wishbone transfer; row/bank/col are the hand-decoded fields of adr.
    task automatic xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int lo, input int rvd, input logic [31:0] rdata,
                        input int init_wait, input bit b2b, input bit tmo,
                        input logic [12:0] row, input logic [1:0] bank, input logic [7:0] col);
        int  e;
        int  a;
        bit  null_wr;
        if (!b2b) @(negedge clk);
        ctl_ready_low = lo; ctl_rv_delay = rvd; ctl_rdata = rdata;
        if (init_wait > 0) local_init_done = 1'b0;
        wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel; wb_we_i = we;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        e = cyc + (b2b ? 2 : 1);
        if (init_wait > 0) begin
            repeat (init_wait) @(negedge clk);
            local_init_done = 1'b1;
            e = cyc + 1;
        end
        null_wr = we && (sel == 4'd0);
        a = e + lo + 1;
        if (!null_wr) cmd_q.push_back('{we, row, bank, col, dat, sel, e, tmo ? 16 : lo + 1});
        if (tmo)          rsp_q.push_back('{1'b1, 1'b0, 32'd0, e + 16});
        else if (null_wr) rsp_q.push_back('{1'b0, 1'b0, 32'd0, e + 1});
        else if (we)      rsp_q.push_back('{1'b0, 1'b0, 32'd0, a});
        else              rsp_q.push_back('{1'b0, 1'b1, rdata, a + rvd});
        @(negedge clk);
        for (int n = 0; n < 300 && !(wb_ack_o || wb_err_o); n++) @(negedge clk);
        if (!(wb_ack_o || wb_err_o)) begin
            $display("FAIL xfer_wait adr=0x%08h: no ack or err within 300 cycles, required one", adr);
            $fatal(1, "transfer timed out");
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int e0;
        reset_n = 1'b0; local_init_done = 1'b1;
        wb_adr_i = 32'd0; wb_dat_i = 32'd0; wb_sel_i = 4'd0; wb_we_i = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        snap_q.push_back('{cyc + 1, 1'b0, 32'd0});
        @(negedge clk);

        // Write, ready high: row 0x1234, bank 1, col 0x5A.
        xfer(1'b1, 32'h0123_4568, 32'hDEAD_BEEF, 4'hF, 0, 1, 32'd0, 0, 1'b0, 1'b0, 13'h1234, 2'd1, 8'h5A);
        // Read back with ready low 3 cycles and rdata 5 cycles after acceptance.
        xfer(1'b0, 32'h0123_4568, 32'd0, 4'hF, 3, 5, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, 13'h1234, 2'd1, 8'h5A);

        // Stray rdata_valid in IDLE must not disturb wb_dat_o.
        @(negedge clk);
        stray_req = stray_req + 1;
        snap_q.push_back('{cyc + 4, 1'b1, 32'hDEAD_BEEF});
        repeat (5) @(negedge clk);

        // Strobe held for 20 cycles before init_done.
        xfer(1'b1, 32'h0000_0004, 32'hCAFE_F00D, 4'h3, 0, 1, 32'd0, 20, 1'b0, 1'b0, 13'h0, 2'd0, 8'h01);
        // Null write: ack only.
        xfer(1'b1, 32'h0000_0100, 32'h0000_00AA, 4'h0, 0, 1, 32'd0, 0, 1'b0, 1'b0, 13'h0, 2'd0, 8'h40);
        // Aliased high address, ready low 2, then back-to-back read of top word address.
        xfer(1'b1, 32'hFE00_0010, 32'h1111_2222, 4'h8, 2, 1, 32'd0, 0, 1'b0, 1'b0, 13'h0, 2'd0, 8'h04);
        xfer(1'b0, 32'h01FF_FFFC, 32'h0BAD_F00D, 4'hF, 0, 1, 32'hA5A5_5A5A, 0, 1'b1, 1'b0, 13'h1FFF, 2'd3, 8'hFF);

        // Reset while waiting for read data; the late rdata_valid follows reset release.
        @(negedge clk);
        ctl_ready_low = 0; ctl_rv_delay = 6; ctl_rdata = 32'h5555_AAAA;
        wb_adr_i = 32'h0000_0808; wb_we_i = 1'b0; wb_dat_i = 32'd0; wb_sel_i = 4'hF;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        e0 = cyc + 1;
        cmd_q.push_back('{1'b0, 13'd0, 2'd2, 8'd2, 32'd0, 4'hF, e0, 1});
        snap_q.push_back('{e0 + 3, 1'b0, 32'd0});
        snap_q.push_back('{e0 + 9, 1'b0, 32'd0});
        while (cyc < e0 + 2) @(negedge clk);
        reset_n = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        while (cyc < e0 + 10) @(negedge clk);

`ifdef DDR_WB_TIMEOUT_EN
        // Ready stuck low: err after 16 CMD cycles, then a write from IDLE.
        xfer(1'b0, 32'h0000_0000, 32'd0, 4'hF, 1000, 1, 32'd0, 0, 1'b0, 1'b1, 13'h0, 2'd0, 8'h00);
        xfer(1'b1, 32'h0000_0C00, 32'h0000_0077, 4'h1, 0, 1, 32'd0, 0, 1'b1, 1'b0, 13'h0, 2'd3, 8'h00);
`endif

        repeat (5) @(negedge clk);
        done = 1'b1;
    end
endmodule
